// File: rtl/stack_reverse_ctrl.sv
// Chunked stream reverser driving an external LIFO: words are pushed until in_last or CAP, then popped out LIFO.
// Output costs 3 cycles per word (POP, LOAD, OUT). out_ready low stalls only in OUT, and in_ready is low outside FILL.
module stack_reverse_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_wdata,
  input  logic [DATA_WIDTH-1:0] stk_rdata,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  input  logic                  stk_error,
  output logic                  err
);

  localparam logic [PTR_WIDTH-1:0] CAP = {PTR_WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, FILL, POP, LOAD, OUT} state_t;

  state_t                  state, state_nxt;
  logic [PTR_WIDTH-1:0]    cnt, cnt_nxt;
  logic                    chunk_last, chunk_last_nxt;
  logic                    out_valid_nxt, out_last_nxt;
  logic [DATA_WIDTH-1:0]   out_data_nxt;
  logic                    err_nxt;
  logic                    op_q;
  logic                    accept;

  assign stk_wdata = in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      chunk_last <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      err        <= 1'b0;
      op_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      chunk_last <= chunk_last_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      out_last   <= out_last_nxt;
      err        <= err_nxt;
      // stk_error refers to the operation issued in the previous cycle
      op_q       <= stk_push | stk_pop;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    chunk_last_nxt = chunk_last;
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    out_last_nxt   = out_last;
    err_nxt        = err | (op_q & stk_error);
    in_ready       = 1'b0;
    stk_push       = 1'b0;
    stk_pop        = 1'b0;
    accept         = 1'b0;

    case (state)
      IDLE: state_nxt = FILL;

      FILL: begin
        in_ready = (cnt < CAP) && !stk_full;
        accept   = in_valid && in_ready;
        stk_push = accept;
        if (accept) begin
          cnt_nxt = cnt + 1'b1;
          if (in_last || (cnt_nxt == CAP)) begin
            chunk_last_nxt = in_last;
            state_nxt      = POP;
          end
        end
      end

      POP: begin
        // A stack that disagrees with our count loses the chunk rather than emitting garbage
        if (stk_empty && (cnt != '0)) begin
          err_nxt        = 1'b1;
          cnt_nxt        = '0;
          chunk_last_nxt = 1'b0;
          state_nxt      = FILL;
        end else begin
          stk_pop   = 1'b1;
          cnt_nxt   = cnt - 1'b1;
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        out_data_nxt  = stk_rdata;
        out_valid_nxt = 1'b1;
        out_last_nxt  = chunk_last && (cnt == '0);
        state_nxt     = OUT;
      end

      OUT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          out_last_nxt  = 1'b0;
          if (cnt != '0) begin
            state_nxt = POP;
          end else begin
            chunk_last_nxt = 1'b0;
            state_nxt      = FILL;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_reverse_ctrl.sv
// Bench for stack_reverse_ctrl: behavioural LIFO model, packet vector table, scoreboard on the output stream.
module tb_stack_reverse_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       stk_push, stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;
  logic       stk_full, stk_empty, stk_error;
  logic       err;

  logic       force_err = 1'b0;
  logic       force_empty = 1'b0;
  logic       model_err;
  logic [7:0] mem [0:3];
  logic [2:0] sp;

  int n_checks = 0;
  int n_pass = 0;
  int n_push = 0;
  int n_pop = 0;
  int proto_bad = 0;
  int busy_bad = 0;
  bit track_off = 1'b0;
  bit chunk_open = 1'b0;
  int acc = 0;
  int outstanding = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;
  exp_t sbq[$];

  typedef struct packed {
    logic [4:0][7:0] d;
    logic [4:0][7:0] e;
    logic [4:0]      el;
    logic [31:0]     len;
    logic            stall;
  } vec_t;
  vec_t vecs [6];

  stack_reverse_ctrl #(.DATA_WIDTH(8), .PTR_WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_error (stk_error),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Depth-4 LIFO, read data registered one cycle after pop
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp        <= 3'd0;
      stk_rdata <= 8'h00;
      model_err <= 1'b0;
    end else begin
      model_err <= 1'b0;
      if (stk_push) begin
        if (sp < 3'd4) begin
          mem[sp[1:0]] <= stk_wdata;
          sp           <= sp + 3'd1;
        end else model_err <= 1'b1;
      end else if (stk_pop) begin
        if (sp > 3'd0) begin
          stk_rdata <= mem[2'(sp - 3'd1)];
          sp        <= sp - 3'd1;
        end else model_err <= 1'b1;
      end
    end
  end

  assign stk_full  = (sp == 3'd4);
  assign stk_empty = (sp == 3'd0) || force_empty;
  assign stk_error = model_err || force_err;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chunk_open  = 1'b0;
      acc         = 0;
      outstanding = 0;
      if (stk_push || stk_pop) proto_bad++;
    end else begin
      if (stk_push && stk_pop) proto_bad++;
      if (stk_push && (stk_wdata !== in_data)) proto_bad++;
      if (stk_push) n_push++;
      if (stk_pop) n_pop++;
      if (chunk_open && in_ready && !track_off) busy_bad++;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", 32'({out_data, out_last}), 32'h1ff);
        end else begin
          exp_t x;
          x = sbq.pop_front();
          check("out_word", 32'({out_data, out_last}), 32'(x));
        end
        if (outstanding > 0) outstanding--;
        if (outstanding == 0) chunk_open = 1'b0;
      end
      if (in_valid && in_ready) begin
        acc++;
        if (in_last || acc == 3) begin
          chunk_open  = 1'b1;
          outstanding = acc;
          acc         = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [7:0] w, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int p0, q0, lat;
    bit ok;

    vecs[0] = '{d: {8'h00, 8'h00, 8'hA3, 8'hA2, 8'hA1}, e: {8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3},
                el: 5'b00100, len: 32'd3, stall: 1'b0};
    vecs[1] = '{d: {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, e: {8'h04, 8'h05, 8'h01, 8'h02, 8'h03},
                el: 5'b10000, len: 32'd5, stall: 1'b0};
    vecs[2] = '{d: {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A}, e: {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A},
                el: 5'b00001, len: 32'd1, stall: 1'b0};
    vecs[3] = '{d: {8'h00, 8'h00, 8'h00, 8'h22, 8'h11}, e: {8'h00, 8'h00, 8'h00, 8'h11, 8'h22},
                el: 5'b00010, len: 32'd2, stall: 1'b1};
    vecs[4] = '{d: {8'h00, 8'hC4, 8'hC3, 8'hC2, 8'hC1}, e: {8'h00, 8'hC4, 8'hC1, 8'hC2, 8'hC3},
                el: 5'b01000, len: 32'd4, stall: 1'b0};
    vecs[5] = '{d: {8'h00, 8'h00, 8'h00, 8'h7C, 8'h6B}, e: {8'h00, 8'h00, 8'h00, 8'h6B, 8'h7C},
                el: 5'b00010, len: 32'd2, stall: 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_stk_push", 32'(stk_push), 32'd0);
    check("rst_stk_pop", 32'(stk_pop), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    #1 check("idle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("fill_in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < int'(vecs[v].len); i++) sbq.push_back({vecs[v].e[i], vecs[v].el[i]});
      p0 = n_push;
      q0 = n_pop;
      out_ready = !vecs[v].stall;
      for (int i = 0; i < int'(vecs[v].len); i++) send(vecs[v].d[i], i == int'(vecs[v].len) - 1);
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("latency_v%0d", v), 32'(lat), 32'd2);
      if (vecs[v].stall) begin
        ok = 1'b1;
        repeat (5) begin
          if (!(out_valid && out_data == 8'h22 && !stk_pop)) ok = 1'b0;
          @(negedge clk);
        end
        check("stall_hold", 32'(ok), 32'd1);
        out_ready = 1'b1;
      end
      drain();
      check($sformatf("push_cnt_v%0d", v), 32'(n_push - p0), vecs[v].len);
      check($sformatf("pop_cnt_v%0d", v), 32'(n_pop - q0), vecs[v].len);
      check($sformatf("err_v%0d", v), 32'(err), 32'd0);
    end

    // Stack error reported the cycle after a push
    sbq.push_back({8'hE2, 1'b0});
    sbq.push_back({8'hE1, 1'b1});
    send(8'hE1, 1'b0);
    force_err = 1'b1;
    check("err_before", 32'(err), 32'd0);
    send(8'hE2, 1'b1);
    force_err = 1'b0;
    check("err_rise", 32'(err), 32'd1);
    drain();
    check("err_sticky", 32'(err), 32'd1);

    // Reset during OUT of a 3-word chunk
    out_ready = 1'b0;
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    sbq.push_back({8'hB2, 1'b0});
    sbq.push_back({8'hB1, 1'b1});
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b1);
    drain();
    check("post_rst_err", 32'(err), 32'd0);

    // Stack claims empty during POP: chunk abandoned, err set, nothing emitted
    track_off = 1'b1;
    q0 = n_pop;
    send(8'hF1, 1'b1);
    force_empty = 1'b1;
    @(negedge clk);
    force_empty = 1'b0;
    check("empty_err", 32'(err), 32'd1);
    check("empty_back_to_fill", 32'(in_ready), 32'd1);
    ok = 1'b1;
    repeat (6) begin
      if (out_valid) ok = 1'b0;
      @(negedge clk);
    end
    check("empty_no_output", 32'(ok), 32'd1);
    check("empty_no_pop", 32'(n_pop - q0), 32'd0);

    check("protocol", 32'(proto_bad), 32'd0);
    check("in_ready_busy", 32'(busy_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
